// File: rtl/cnn_pkg.sv
// cnn_pkg: shared widths, word/address types and block state enums for the CNN memory movers.
package cnn_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} store_state_t;
  typedef enum logic [1:0] {LD_IDLE, LD_REQ, LD_DONE} load_state_t;
endpackage

// File: rtl/store_block_if.sv
// store_block_if: producer stream, start/size/base control and DMA write port of store_block.
interface store_block_if;
  import cnn_pkg::*;
  logic enable;
  logic [15:0] size;
  addr_t address;
  word_t inData;
  logic inValid;
  logic inReady;
  logic dmaGrant;
  logic dmaEnable;
  logic RW;
  addr_t dmaAddr;
  word_t dmaOut;
  logic done;
  modport master (output enable, size, address, inData, inValid, dmaGrant,
                  input inReady, dmaEnable, RW, dmaAddr, dmaOut, done);
  modport slave (input enable, size, address, inData, inValid, dmaGrant,
                 output inReady, dmaEnable, RW, dmaAddr, dmaOut, done);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: registered FIFO; push refused when full, pop ignored when empty.
module sync_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wrData,
  output logic [W-1:0] rdData,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  logic doPush, doPop;
  assign doPush = push && !full;
  assign doPop = pop && !empty;
  assign empty = wrPtr == rdPtr;
  assign full = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign rdData = mem[rdPtr[AW-1:0]];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
    end
  always_ff @(posedge clk)
    if (doPush) mem[wrPtr[AW-1:0]] <= wrData;
endmodule

// File: rtl/store_block.sv
// store_block: buffers a layer's result stream and writes size*size words to consecutive DMA addresses.
module store_block
  import cnn_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  store_block_if.slave bus
);
  store_state_t state;
  addr_t base;
  logic [15:0] total, inCount, wrCount, sq;
  word_t head;
  logic full, empty, push, pop, wrEn;
  assign sq = bus.size * bus.size;
  assign bus.inReady = state == ST_RUN && !full && inCount < total;
  assign wrEn = state == ST_RUN && !empty;
  assign push = bus.inValid && bus.inReady;
  assign pop = wrEn && bus.dmaGrant;
  assign bus.dmaEnable = wrEn;
  assign bus.RW = wrEn;
  assign bus.dmaAddr = wrEn ? addr_t'(base + wrCount) : '0;
  assign bus.dmaOut = wrEn ? head : '0;
  assign bus.done = state == ST_DONE;
  sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .wrData(bus.inData), .rdData(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      base <= '0;
      total <= '0;
      inCount <= '0;
      wrCount <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.enable) begin
          base <= bus.address;
          total <= sq;
          inCount <= '0;
          wrCount <= '0;
          state <= sq == '0 ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (push) inCount <= inCount + 16'd1;
          if (pop) begin
            wrCount <= wrCount + 16'd1;
            if (wrCount + 16'd1 == total) state <= ST_DONE;
          end
        end
        ST_DONE: if (!bus.enable) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_store_block.sv
// tb_store_block: directed vectors for store_block with a commit log checked against hand-computed addresses/data.
module tb_store_block;
  import cnn_pkg::*;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  store_block_if bus();
  store_block #(.FIFO_DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  int tests = 0, fails = 0, accIdx = 0, prodN = 0, tickN = 0, lastCommit = -1, rwBad = 0;
  logic prodOn = 0;
  word_t words [16];
  addr_t cAddr [$];
  word_t cData [$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive();
    bus.inValid = prodOn && accIdx < prodN;
    bus.inData = accIdx < 16 ? words[accIdx] : '0;
  endtask
  // Handshakes are sampled at the falling edge; they take effect on the next rising edge.
  task automatic tick();
    tickN++;
    @(negedge clk);
    if (bus.RW !== bus.dmaEnable) rwBad++;
    if (!reset && bus.dmaEnable && bus.dmaGrant) begin
      cAddr.push_back(bus.dmaAddr);
      cData.push_back(bus.dmaOut);
      lastCommit = tickN;
    end
    if (!reset && bus.inValid && bus.inReady) accIdx++;
    @(posedge clk);
    #1;
    drive();
  endtask
  task automatic start(input logic [15:0] sz, input addr_t addr, input int n);
    prodN = n;
    accIdx = 0;
    cAddr.delete();
    cData.delete();
    bus.enable = 1;
    bus.size = sz;
    bus.address = addr;
    prodOn = 1;
    drive();
  endtask
  task automatic waitDone(input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      tick();
      n++;
    end
    check("doneWithinBudget", bus.done, 1);
  endtask
  task automatic finishImage();
    bus.enable = 0;
    prodOn = 0;
    drive();
    tick();
    check("doneClears", bus.done, 0);
  endtask
  task automatic expectWrites(input string tag, input addr_t base, input int n);
    check({tag, "Count"}, cAddr.size(), n);
    for (int i = 0; i < n && i < cAddr.size(); i++) begin
      check({tag, "Addr"}, cAddr[i], addr_t'(base + addr_t'(i)));
      check({tag, "Data"}, cData[i], words[i]);
    end
  endtask
  task automatic expectIdleOutputs(input string tag);
    check({tag, "InReady"}, bus.inReady, 0);
    check({tag, "DmaEnable"}, bus.dmaEnable, 0);
    check({tag, "RW"}, bus.RW, 0);
    check({tag, "DmaAddr"}, bus.dmaAddr, 0);
    check({tag, "DmaOut"}, bus.dmaOut, 0);
    check({tag, "Done"}, bus.done, 0);
  endtask
  initial begin
    int n;
    for (int i = 0; i < 16; i++) words[i] = 16'hC000 + 16'(i * 16'h0101);
    bus.enable = 0;
    bus.size = '0;
    bus.address = '0;
    bus.inData = '0;
    bus.inValid = 0;
    bus.dmaGrant = 0;
    repeat (2) @(posedge clk);
    #1;
    expectIdleOutputs("reset");
    reset = 0;
    tick();
    bus.dmaGrant = 1;
    start(16'd2, 16'h0100, 4);
    waitDone(40);
    check("basicDoneAfterLastCommit", tickN - lastCommit, 0);
    expectWrites("basic", 16'h0100, 4);
    repeat (3) tick();
    check("basicDoneHeld", bus.done, 1);
    finishImage();
    bus.dmaGrant = 0;
    start(16'd3, 16'h0300, 9);
    repeat (10) tick();
    check("bpAccepted", accIdx, 4);
    check("bpInReady", bus.inReady, 0);
    check("bpDmaEnable", bus.dmaEnable, 1);
    check("bpAddrHeld", bus.dmaAddr, 16'h0300);
    check("bpDataHeld", bus.dmaOut, words[0]);
    bus.dmaGrant = 1;
    waitDone(60);
    check("bpAcceptedAll", accIdx, 9);
    expectWrites("bp", 16'h0300, 9);
    finishImage();
    start(16'd2, 16'hFFFE, 4);
    waitDone(40);
    expectWrites("wrap", 16'hFFFE, 4);
    finishImage();
    start(16'd0, 16'h0500, 2);
    tick();
    check("zeroDone", bus.done, 1);
    check("zeroAccepted", accIdx, 0);
    expectWrites("zero", 16'h0500, 0);
    finishImage();
    start(16'd2, 16'h0600, 6);
    n = 0;
    while (accIdx < 4 && n < 20) begin
      tick();
      n++;
    end
    check("ovInReadyAfter4", bus.inReady, 0);
    check("ovStillRunning", bus.done, 0);
    waitDone(40);
    check("ovAccepted", accIdx, 4);
    expectWrites("ov", 16'h0600, 4);
    finishImage();
    start(16'd3, 16'h0400, 9);
    n = 0;
    while (cAddr.size() < 2 && n < 30) begin
      tick();
      n++;
    end
    check("midCommits", cAddr.size(), 2);
    reset = 1;
    #1;
    expectIdleOutputs("midReset");
    bus.enable = 0;
    prodOn = 0;
    drive();
    repeat (2) tick();
    check("resetHeldNoWrite", bus.dmaEnable, 0);
    reset = 0;
    tick();
    start(16'd1, 16'h0200, 1);
    waitDone(30);
    expectWrites("restart", 16'h0200, 1);
    finishImage();
    check("rwTracksEnable", rwBad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
